// File: rtl/mem_ctrl_responder_pkg.sv
// Shared constants, size/state encodings and helpers for the memory controller
// that arbitrates the icache fetcher and the LSB over one byte-wide RAM port.
package mem_ctrl_responder_pkg;

  localparam int          BLOCK_BYTES = 16;
  localparam logic [31:0] IO_BASE     = 32'h0003_0000;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_LS_RD = 2'd2,
    ST_LS_WR = 2'd3
  } state_t;

  // Byte count of an LSB access; the unused encoding is treated as a word.
  function automatic logic [4:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 5'd1;
      SIZE_H:  size_bytes = 5'd2;
      default: size_bytes = 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_responder.sv
// Serves icache block fills and LSB loads/stores as byte sequences on the RAM
// port; a single counter and byte buffer are shared by every transaction type.
module mem_ctrl_responder
  import mem_ctrl_responder_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         fetch_enable,
  input  logic [31:0]  fetch_addr,
  output logic [127:0] inst_block_to_if,
  output logic         finish_sign_to_if,
  input  logic         lsb_enable,
  input  logic         lsb_wr,
  input  logic [1:0]   lsb_size,
  input  logic [31:0]  lsb_addr,
  input  logic [31:0]  lsb_wdata,
  output logic [31:0]  lsb_rdata,
  output logic         lsb_finish,
  input  logic         rollback_sign_from_rob,
  input  logic [7:0]   mem_din,
  output logic [7:0]   mem_dout,
  output logic [31:0]  mem_a,
  output logic         mem_wr,
  input  logic         io_buffer_full
);

  // Handshake: fetch_enable / lsb_enable are single-cycle request pulses that
  // are only legal while that client has nothing pending or in service; each
  // request is answered by exactly one single-cycle finish pulse unless a
  // rollback discards it (stores already in flight always finish).

  state_t         state;
  logic           fetch_pend;
  logic           lsb_pend;
  logic [31:0]    fetch_base;
  logic [31:0]    ls_addr;
  logic [31:0]    ls_wdata;
  logic [1:0]     ls_size;
  logic           ls_wr;
  logic [31:0]    cur_addr;
  logic [4:0]     cur_len;
  logic [4:0]     cnt;
  logic [4:0]     cnt_inc;
  logic [3:0]     cap_idx;
  logic [127:0]   blk;
  logic [127:0]   blk_next;
  logic           capture;
  logic           wr_active;
  logic           stall;
  logic           if_done_q;
  logic           ls_done_q;
  logic           fetch_accept;
  logic           lsb_accept;
  logic           rollback;

  assign rollback = rollback_sign_from_rob;
  assign cnt_inc  = cnt + 5'd1;
  assign cap_idx  = 4'(cnt - 5'd1);

  // A fetch pulse riding on a rollback carries the new PC, so it is never busy.
  assign fetch_accept = fetch_enable &&
                        (rollback || !(fetch_pend || state == ST_IF_RD));
  assign lsb_accept   = lsb_enable && !rollback &&
                        !(lsb_pend || state == ST_LS_RD || state == ST_LS_WR);

  // Read byte j-1 arrives while the counter shows j (one-cycle RAM latency).
  assign capture = (state == ST_IF_RD || state == ST_LS_RD) &&
                   (cnt != 5'd0) && (cnt <= cur_len);

  always_comb begin
    blk_next = blk;
    if (capture) begin
      blk_next[{cap_idx, 3'b000} +: 8] = mem_din;
    end
  end

  assign wr_active = (state == ST_LS_WR) && (cnt < cur_len);
  assign stall     = wr_active && (mem_a >= IO_BASE) && io_buffer_full;

  assign mem_wr            = rdy && wr_active && !stall;
  assign finish_sign_to_if = rdy && if_done_q;
  assign lsb_finish        = rdy && ls_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      fetch_pend       <= 1'b0;
      lsb_pend         <= 1'b0;
      fetch_base       <= '0;
      ls_addr          <= '0;
      ls_wdata         <= '0;
      ls_size          <= SIZE_B;
      ls_wr            <= 1'b0;
      cur_addr         <= '0;
      cur_len          <= '0;
      cnt              <= '0;
      blk              <= '0;
      mem_a            <= '0;
      mem_dout         <= '0;
      inst_block_to_if <= '0;
      lsb_rdata        <= '0;
      if_done_q        <= 1'b0;
      ls_done_q        <= 1'b0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;

      if (rollback) begin
        fetch_pend <= 1'b0;
        lsb_pend   <= 1'b0;
      end
      if (fetch_accept) begin
        fetch_pend <= 1'b1;
        fetch_base <= fetch_addr;
      end
      if (lsb_accept) begin
        lsb_pend <= 1'b1;
        ls_addr  <= lsb_addr;
        ls_wdata <= lsb_wdata;
        ls_size  <= lsb_size;
        ls_wr    <= lsb_wr;
      end

      case (state)
        ST_IDLE: begin
          if (!rollback) begin
            if (lsb_pend) begin
              lsb_pend <= 1'b0;
              state    <= ls_wr ? ST_LS_WR : ST_LS_RD;
              cur_addr <= ls_addr;
              cur_len  <= size_bytes(ls_size);
              cnt      <= '0;
              blk      <= '0;
              mem_a    <= ls_addr;
              mem_dout <= ls_wdata[7:0];
            end else if (fetch_pend) begin
              fetch_pend <= 1'b0;
              state      <= ST_IF_RD;
              cur_addr   <= fetch_base;
              cur_len    <= 5'(BLOCK_BYTES);
              cnt        <= '0;
              blk        <= '0;
              mem_a      <= fetch_base;
            end
          end
        end

        ST_IF_RD, ST_LS_RD: begin
          if (rollback) begin
            state <= ST_IDLE;
          end else begin
            blk <= blk_next;
            cnt <= cnt_inc;
            if (cnt_inc < cur_len) begin
              mem_a <= cur_addr + {27'd0, cnt_inc};
            end
            if (cnt == cur_len) begin
              if (state == ST_IF_RD) begin
                inst_block_to_if <= blk_next;
                if_done_q        <= 1'b1;
              end else begin
                lsb_rdata <= blk_next[31:0];
                ls_done_q <= 1'b1;
              end
            end
            // The finish cycle itself stays in the read state; IDLE follows.
            if (cnt == cur_len + 5'd1) begin
              state <= ST_IDLE;
            end
          end
        end

        ST_LS_WR: begin
          if (cnt == cur_len) begin
            state <= ST_IDLE;
          end else if (!stall) begin
            cnt      <= cnt_inc;
            mem_a    <= cur_addr + {27'd0, cnt_inc};
            mem_dout <= ls_wdata[{cnt_inc[1:0], 3'b000} +: 8];
            if (cnt_inc == cur_len) begin
              ls_done_q <= 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl_responder.md
# mem_ctrl_responder

Memory controller that serves both memory clients of the core over the single byte-wide RAM port. It answers instruction-block fill requests from the fetcher's icache and load/store requests from the LSB. Each request becomes a sequence of byte reads or writes, and the controller returns an assembled block or word with a one-cycle finish pulse. It sits between the fetcher/LSB and the top-level RAM/IO bus, and it honours ROB rollback.

## Interface
- BLOCK_BYTES, 16: bytes per icache block (4 instructions, 128 bits).
- IO_BASE, 32'h30000: addresses at or above this are I/O.
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- fetch_enable  in  1  one-cycle request pulse from fetcher
- fetch_addr  in  32  block base address, low 4 bits zero
- inst_block_to_if  out  128  assembled block, byte 0 in bits [7:0]
- finish_sign_to_if  out  1  one-cycle pulse, block valid
- lsb_enable  in  1  one-cycle request pulse from LSB
- lsb_wr  in  1  1 = store, 0 = load
- lsb_size  in  2  0: 1 byte, 1: 2 bytes, 2: 4 bytes
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data, little-endian
- lsb_rdata  out  32  load data, zero-extended
- lsb_finish  out  1  one-cycle pulse, load data valid or store done
- rollback_sign_from_rob  in  1  flush speculative requests
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  I/O write buffer full

## Operation
- Request latching:
  - Each enable pulse sets a pending flag (fetch_pend or lsb_pend) and latches its address, size, wr and data.
  - A new pulse while the same client is pending or in service is a protocol violation and is ignored.
- States:
  - IDLE: selects the next client.
  - IF_RD: block read.
  - LS_RD: load.
  - LS_WR: store.
- Arbitration in IDLE:
  - lsb_pend has priority over fetch_pend.
  - The chosen client's pending flag clears on entry to its state.
- IF_RD:
  - Issue addresses base+0 through base+15 on consecutive cycles.
  - Capture mem_din one cycle after each address into block byte i.
  - After byte 15 is captured, drive inst_block_to_if and pulse finish_sign_to_if, then return to IDLE.
- LS_RD:
  - Same scheme with N = 1, 2 or 4 bytes.
  - Bytes fill lsb_rdata from bit 0 upward; upper bytes are 0.
  - Pulse lsb_finish, then return to IDLE.
- LS_WR:
  - Each cycle: mem_a = addr+i, mem_dout = wdata byte i, mem_wr = 1, for N cycles.
  - Pulse lsb_finish in the cycle after the last byte.
  - If addr ≥ IO_BASE and io_buffer_full = 1, the byte is not issued (mem_wr = 0, counter held) until full drops.
- Rollback:
  - Clears fetch_pend and aborts IF_RD immediately with no finish.
  - Clears lsb_pend and aborts a load.
  - A store in LS_WR always completes, because it is committed.
  - The next cycle is IDLE, or the store continues.
- A fetch_enable in the same cycle as rollback is accepted, since the new PC arrives with it.
- rdy = 0: no state change, mem_wr forced 0, finish pulses held low.

## Timing
- Reset values:
  - state IDLE, pending flags 0.
  - mem_a 0, mem_dout 0, mem_wr 0.
  - inst_block_to_if 0, finish_sign_to_if 0.
  - lsb_rdata 0, lsb_finish 0.
- RAM latency: data for the mem_a driven in cycle k is valid on mem_din in cycle k+1.
- Fetch, request pulse in cycle 0:
  - Cycle 1: IDLE grants.
  - Cycles 2–17: addresses.
  - Cycles 3–18: data captured.
  - Cycle 19: finish.
  - Latency is 19 cycles; in general BLOCK_BYTES+3.
- Load of N bytes: finish in cycle N+3 after the pulse.
- Store of N bytes: bytes in cycles 2 to N+1, finish in cycle N+2, assuming no I/O stall.
- One IDLE cycle between transactions; mem_wr = 0 in IDLE.
- Simultaneous pulses in cycle 0: the LSB is served first and the fetch starts in the IDLE cycle after lsb_finish.

## Structure
- Shared defines file holds:
  - BLOCK_BYTES, IO_BASE.
  - size encodings SIZE_B/H/W.
  - state encodings.
- No sub-module; the byte counter and shift-in logic are shared by all states.

## Test plan
- Reset, then fetch pulse at addr 0x100 with RAM[0x100..0x10F] = 0x00..0x0F -> finish_sign_to_if in cycle 19 with inst_block_to_if = 0x0F0E…0100.
- Load size 2 at 0x204 with RAM = {0x34, 0x12} -> lsb_finish in cycle 5, lsb_rdata = 0x00001234.
- Store word 0xDEADBEEF at 0x300 -> mem_wr high for 4 cycles with mem_dout EF, BE, AD, DE at 0x300–0x303, then lsb_finish.
- Fetch and LSB load pulsed together -> load finishes first, fetch finishes 19 cycles after lsb_finish plus 1 IDLE cycle.
- Rollback in cycle 8 of a fetch -> no finish_sign_to_if, IDLE next cycle; a fetch re-pulsed with the rollback is served from its own address.
- Store byte to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write, then lsb_finish.
